// File: rtl/decode_stage.sv
// decode_stage -- pipelined MIPS32 decode stage.
//
// Buffers fetched {pc, inst} pairs in a DEPTH-entry FIFO, decodes the FIFO
// head and presents the decoded fields in a registered output stage. Both
// sides use valid/ready handshakes. Up to DEPTH+1 instructions can be in
// flight (FIFO plus output register), and order is strictly preserved.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   flush                 drop everything buffered and the output stage
//   in_valid/in_ready     fetch handshake; in_pc / in_inst are the payload
//   out_valid/out_ready   execute handshake
//   out_pc, out_inst      passthrough of the decoded instruction
//   out_inst_type         2'b00 R, 2'b01 I, 2'b10 J
//   out_op_code, out_funct, out_rs, out_rt, out_rd, out_shamt
//                         instruction fields (funct/rd/shamt are 0 for non-R)
//   out_imm               extended immediate, shift amount or jump target
//   out_wreg              destination register, 0 = no writeback
//   out_illegal           opcode is not in the supported set
//   count                 FIFO occupancy, excluding the output register
module decode_stage #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_pc,
  input  logic [W-1:0]     in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_pc,
  output logic [W-1:0]     out_inst,
  output logic [1:0]       out_inst_type,
  output logic [5:0]       out_op_code,
  output logic [5:0]       out_funct,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_shamt,
  output logic [W-1:0]     out_imm,
  output logic [4:0]       out_wreg,
  output logic             out_illegal,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_I = 2'b01;
  localparam logic [1:0] TYPE_J = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // ---------------------------------------------------------------------
  // FIFO storage and control
  // ---------------------------------------------------------------------
  logic [2*W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign in_ready = (count != CNT_W'(DEPTH));
  assign push     = in_valid & in_ready & ~flush;
  // The output register can take a new entry when it is empty or when its
  // current entry is being consumed this cycle.
  assign pop      = (count != '0) & (~out_valid | out_ready) & ~flush;

  // NOTE: the storage array carries no reset; only pointers and count define
  // which entries are meaningful, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_pc, in_inst};
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---------------------------------------------------------------------
  // Decode of the FIFO head
  // ---------------------------------------------------------------------
  logic [W-1:0] head_pc;
  logic [W-1:0] head_inst;
  logic [W-1:0] pcp4;
  logic [5:0]   op;
  logic [5:0]   fn;
  logic [W-1:0] sext;
  logic [W-1:0] zext;

  logic [1:0]   d_type;
  logic [5:0]   d_funct;
  logic [4:0]   d_rd;
  logic [4:0]   d_shamt;
  logic [W-1:0] d_imm;
  logic [4:0]   d_wreg;
  logic         d_illegal;

  assign head_pc   = mem[rd_ptr][2*W-1:W];
  assign head_inst = mem[rd_ptr][W-1:0];
  assign pcp4      = head_pc + W'(4);
  assign op        = head_inst[31:26];
  assign fn        = head_inst[5:0];
  assign sext      = {{16{head_inst[15]}}, head_inst[15:0]};
  assign zext      = {16'h0000, head_inst[15:0]};

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a value unassigned (no latches).
  always_comb begin
    d_type    = TYPE_I;
    d_funct   = '0;
    d_rd      = '0;
    d_shamt   = '0;
    d_imm     = '0;
    d_wreg    = '0;
    d_illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        d_type  = TYPE_R;
        d_funct = fn;
        d_rd    = head_inst[15:11];
        d_shamt = head_inst[10:6];
        if (fn == FN_SLL || fn == FN_SRL || fn == FN_SRA) begin
          d_imm = W'(head_inst[10:6]);
        end
        // JR only redirects control flow; it has no register result.
        d_wreg = (fn == FN_JR) ? 5'd0 : head_inst[15:11];
      end
      OP_J, OP_JAL: begin
        d_type = TYPE_J;
        d_imm  = {pcp4[W-1:W-4], head_inst[25:0], 2'b00};
        d_wreg = (op == OP_JAL) ? 5'd31 : 5'd0;
      end
      // Branches and REGIMM: signed offset, no writeback.
      6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
        d_imm = sext;
      end
      // ADDI, ADDIU, SLTI, SLTIU and the loads write rt.
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
        d_imm  = sext;
        d_wreg = head_inst[20:16];
      end
      // ANDI, ORI, XORI are logical and take a zero-extended operand.
      6'b001100, 6'b001101, 6'b001110: begin
        d_imm  = zext;
        d_wreg = head_inst[20:16];
      end
      OP_LUI: begin
        d_imm  = {head_inst[15:0], 16'h0000};
        d_wreg = head_inst[20:16];
      end
      // Stores: signed offset, no writeback.
      6'b101000, 6'b101001, 6'b101011: begin
        d_imm = sext;
      end
      default: begin
        d_illegal = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_inst      <= '0;
      out_inst_type <= '0;
      out_op_code   <= '0;
      out_funct     <= '0;
      out_rs        <= '0;
      out_rt        <= '0;
      out_rd        <= '0;
      out_shamt     <= '0;
      out_imm       <= '0;
      out_wreg      <= '0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      // Fields may go stale after a flush; only out_valid matters.
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid     <= 1'b1;
      out_pc        <= head_pc;
      out_inst      <= head_inst;
      out_inst_type <= d_type;
      out_op_code   <= op;
      out_funct     <= d_funct;
      out_rs        <= head_inst[25:21];
      out_rt        <= head_inst[20:16];
      out_rd        <= d_rd;
      out_shamt     <= d_shamt;
      out_imm       <= d_imm;
      out_wreg      <= d_wreg;
      out_illegal   <= d_illegal;
    end else if (out_ready) begin
      // Consumed with nothing behind it: drop valid, hold the fields.
      out_valid <= 1'b0;
    end
  end

endmodule
